// File: rtl/reg_serial_reader_pkg.sv
// Shared types and helpers for the serial read-out of a parallel-load register word.
// State encoding is fixed so the register bank debug view can decode it directly.
package reg_serial_reader_pkg;

    localparam int unsigned DefaultWidth = 16;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    // Bits needed to hold values 0..value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_serial_reader_bit_down_counter.sv
// Bit index counter for the serial reader: loads a start index, counts down to zero and
// holds there; zero flags the last bit of the word.
module reg_serial_reader_bit_down_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - Width'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/reg_serial_reader.sv
// Serial read-out of a stored register word: load handshake, one bit per enabled clock,
// one-cycle done pulse. All outputs are registered; nothing combinational from inputs.
module reg_serial_reader
    import reg_serial_reader_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic             load,
    input  logic             en,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done,
    output logic             busy
);

    localparam int unsigned     CntW    = clog2(WIDTH);
    localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_shifted;
    logic             first_bit;
    logic             next_bit;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_zero;

    always_comb begin
        shreg_shifted = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
        first_bit     = LSB_FIRST ? D[0] : D[WIDTH-1];
        next_bit      = LSB_FIRST ? shreg_shifted[0] : shreg_shifted[WIDTH-1];
        cnt_load      = (state_q == StIdle) && load;
        cnt_dec       = (state_q == StShift) && en && !cnt_zero;
    end

    reg_serial_reader_bit_down_counter #(
        .Width (CntW)
    ) u_bit_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LastIdx),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Outputs are set from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            ready      <= 1'b1;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (load) begin
                        state_q    <= StShift;
                        shreg_q    <= D;
                        ready      <= 1'b0;
                        busy       <= 1'b1;
                        sout_valid <= 1'b1;
                        sout       <= first_bit;
                    end
                end
                StShift: begin
                    if (en) begin
                        if (!cnt_zero) begin
                            shreg_q <= shreg_shifted;
                            sout    <= next_bit;
                        end else begin
                            state_q    <= StDone;
                            shreg_q    <= '0;
                            sout       <= 1'b0;
                            sout_valid <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    ready   <= 1'b1;
                end
                default: begin
                    state_q    <= StIdle;
                    shreg_q    <= '0;
                    ready      <= 1'b1;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_serial_reader.sv
// Bench for reg_serial_reader: scoreboard queues of expected bits per instance,
// checked on the falling edge while sout_valid is high.
module tb_reg_serial_reader;

    logic        clk;
    logic        rst;
    logic [15:0] d0, d1;
    logic        load0, load1, en0, en1;
    logic        ready0, sout0, sout_valid0, done0, busy0;
    logic        ready1, sout1, sout_valid1, done1, busy1;

    int n_checks;
    int n_errors;
    int done_cnt0;
    int done_cnt1;
    bit exp_q0[$];
    bit exp_q1[$];

    reg_serial_reader #(
        .WIDTH     (16),
        .LSB_FIRST (1'b0)
    ) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .D          (d0),
        .load       (load0),
        .en         (en0),
        .ready      (ready0),
        .sout       (sout0),
        .sout_valid (sout_valid0),
        .done       (done0),
        .busy       (busy0)
    );

    reg_serial_reader #(
        .WIDTH     (16),
        .LSB_FIRST (1'b1)
    ) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .D          (d1),
        .load       (load1),
        .en         (en1),
        .ready      (ready1),
        .sout       (sout1),
        .sout_valid (sout_valid1),
        .done       (done1),
        .busy       (busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit is consumed at the next posedge only when en is high; until then it must hold.
    always @(negedge clk) begin
        if (rst) begin
            if (sout_valid0) begin
                check_eq("bit_pending_msb", exp_q0.size() > 0, 1);
                if (exp_q0.size() > 0) begin
                    check_eq("sout_msb", sout0, exp_q0[0]);
                    if (en0) void'(exp_q0.pop_front());
                end
            end else begin
                check_eq("sout_idle_msb", sout0, 0);
            end
            if (sout_valid1) begin
                check_eq("bit_pending_lsb", exp_q1.size() > 0, 1);
                if (exp_q1.size() > 0) begin
                    check_eq("sout_lsb", sout1, exp_q1[0]);
                    if (en1) void'(exp_q1.pop_front());
                end
            end else begin
                check_eq("sout_idle_lsb", sout1, 0);
            end
            if (done0) done_cnt0++;
            if (done1) done_cnt1++;
        end
    end

    task automatic run_word(input bit sel, input logic [15:0] word, input int stall_lo,
                            input int stall_hi, input bit inject, input int exp_done);
        int cyc;
        bit got_done;
        int dc_before;
        @(posedge clk);
        #1;
        dc_before = sel ? done_cnt1 : done_cnt0;
        if (sel) begin
            d1 = word; load1 = 1'b1; en1 = 1'b1;
            for (int i = 0; i < 16; i++) exp_q1.push_back(word[i]);
        end else begin
            d0 = word; load0 = 1'b1; en0 = 1'b1;
            for (int i = 15; i >= 0; i--) exp_q0.push_back(word[i]);
        end
        @(posedge clk);
        #1;
        load0 = 1'b0;
        load1 = 1'b0;
        cyc = 1;
        got_done = 1'b0;
        while (!got_done && cyc <= 60) begin
            if (sel) en1 = !(cyc >= stall_lo && cyc <= stall_hi);
            else     en0 = !(cyc >= stall_lo && cyc <= stall_hi);
            if (inject && cyc == 4) begin
                load0 = 1'b1;
                d0    = 16'h0000;
            end else begin
                load0 = 1'b0;
            end
            @(negedge clk);
            got_done = sel ? done1 : done0;
            if (got_done) begin
                check_eq("busy_in_done", sel ? busy1 : busy0, 1);
                check_eq("ready_in_done", sel ? ready1 : ready0, 0);
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        check_eq("done_seen", got_done, 1);
        check_eq("done_cycle", cyc, exp_done);
        @(posedge clk);
        #1;
        en0 = 1'b1;
        en1 = 1'b1;
        @(negedge clk);
        check_eq("done_one_cycle", sel ? done1 : done0, 0);
        check_eq("ready_after", sel ? ready1 : ready0, 1);
        check_eq("busy_after", sel ? busy1 : busy0, 0);
        check_eq("bits_all_out", sel ? exp_q1.size() : exp_q0.size(), 0);
        check_eq("single_done", (sel ? done_cnt1 : done_cnt0) - dc_before, 1);
    endtask

    initial begin
        int dc_abort;
        n_checks = 0; n_errors = 0; done_cnt0 = 0; done_cnt1 = 0;
        rst = 1'b1;
        d0 = '0; d1 = '0; load0 = 1'b0; load1 = 1'b0; en0 = 1'b0; en1 = 1'b0;

        // Asynchronous reset mid-cycle, before any clock edge.
        #3 rst = 1'b0;
        #1;
        check_eq("rst_ready", ready0, 1);
        check_eq("rst_busy", busy0, 0);
        check_eq("rst_sout", sout0, 0);
        check_eq("rst_valid", sout_valid0, 0);
        check_eq("rst_done", done0, 0);
        check_eq("rst_ready_lsb", ready1, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        en0 = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("idle_ready", ready0, 1);
            check_eq("idle_busy", busy0, 0);
            check_eq("idle_valid", sout_valid0, 0);
        end

        run_word(1'b0, 16'hA5C3, 0, -1, 1'b0, 17);
        run_word(1'b0, 16'h8001, 3, 5, 1'b0, 20);
        run_word(1'b0, 16'hFFFF, 0, -1, 1'b1, 17);

        // Abort after five bits have been shifted.
        dc_abort = done_cnt0;
        @(posedge clk);
        #1;
        d0 = 16'h1234; load0 = 1'b1; en0 = 1'b1;
        for (int i = 15; i >= 0; i--) exp_q0.push_back(d0[i]);
        @(posedge clk);
        #1 load0 = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_eq("abort_ready", ready0, 1);
        check_eq("abort_busy", busy0, 0);
        check_eq("abort_valid", sout_valid0, 0);
        check_eq("abort_sout", sout0, 0);
        check_eq("abort_done", done0, 0);
        check_eq("abort_bits_left", exp_q0.size(), 11);
        exp_q0.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("post_abort_busy", busy0, 0);
        end
        check_eq("abort_no_done", done_cnt0 - dc_abort, 0);

        run_word(1'b0, 16'h00FF, 0, -1, 1'b0, 17);
        run_word(1'b1, 16'h0001, 0, -1, 1'b0, 17);
        run_word(1'b1, 16'hC0DE, 2, 2, 1'b0, 18);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_serial_reader.md
Name: reg_serial_reader

Overview:
- Read-side counterpart of the 16-bit parallel-load register.
- Takes a stored word on a load handshake and shifts it out one bit per enabled clock on a serial line, with a qualifying valid flag.
- Signals completion with a one-cycle done pulse, then accepts the next word.
- Sits between the register bank and the serial output/debug path of the digital system.

Parameters:
WIDTH, 16, word width in bits (legal range 2..32)
LSB_FIRST, 0, 0 = shift out MSB first, 1 = shift out LSB first

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
D  input  WIDTH  parallel word to read out; sampled only on an accepted load
load  input  1  request to start a read-out
en  input  1  shift enable; 0 stalls the current bit
ready  output  1  block idle and able to accept load
sout  output  1  current serial bit
sout_valid  output  1  sout carries a data bit this cycle
done  output  1  one-cycle pulse after the last bit has been shifted
busy  output  1  read-out in progress (state != IDLE)

Behaviour:
- Reset (rst=0, async, any state): state=IDLE, shift register=0, bit counter=0.
- Outputs during reset: ready=1, sout=0, sout_valid=0, done=0, busy=0.
- Release of reset is synchronous to the next clk edge.
- States are IDLE, SHIFT and DONE; all outputs decode from registered state, so there are no combinational paths from inputs to outputs.
- IDLE:
  - ready=1, busy=0, sout_valid=0, sout=0.
  - On posedge with load=1: capture D into the shift register, counter=WIDTH-1, go to SHIFT.
  - load=0: stay in IDLE.
- SHIFT:
  - ready=0, busy=1, sout_valid=1.
  - sout = shift register MSB (LSB_FIRST=0) or LSB (LSB_FIRST=1).
  - On posedge with en=1 and counter>0: shift by one toward the output end, fill with 0, decrement counter.
  - On posedge with en=1 and counter==0: go to DONE.
  - en=0: hold the shift register, counter and sout unchanged; no bit is lost.
- DONE:
  - ready=0, busy=1, sout_valid=0, sout=0, done=1 for exactly one cycle.
  - Unconditionally return to IDLE on the next posedge.
- Latency:
  - First bit is valid in the cycle after load is accepted.
  - With en held at 1, bit k (k = 0..WIDTH-1) is presented in cycle k+1.
  - done is asserted in cycle WIDTH+1.
  - Next load can be accepted at the posedge ending cycle WIDTH+2.
- load while ready=0 (SHIFT or DONE): ignored, not queued. D changes during SHIFT have no effect.
- load and en asserted together in IDLE: only the load is acted on; en is irrelevant in IDLE.
- Counter width: clog2(WIDTH) bits; never wraps below 0 because the exit happens at 0.
- Reset asserted mid-word: read-out is aborted immediately and the partial word is discarded; no done pulse.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10)
  - default WIDTH=16, matching the register word
  - a clog2 helper function for counter sizing
- One natural sub-module: bit_down_counter.
  - Ports: clk, rst, load value, decrement enable, zero flag.
  - Instantiated once for the bit index.
- Shift register and FSM stay in the top module.

Test Plan:
- Reset then idle: rst=0 mid-cycle -> ready=1, busy=0, sout=0, sout_valid=0, done=0 immediately (async); all hold after rst=1 with load=0.
- MSB-first read-out:
  - Stimulus: D=16'hA5C3, load=1 for one cycle, en=1.
  - Required: sout sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on cycles 1..16 with sout_valid=1; done=1 in cycle 17 only; ready=1 in cycle 18.
- Stall:
  - Stimulus: D=16'h8001, en=0 for cycles 3..5.
  - Required: sout stays at bit 2 (0) through the stall; total bits=16; done is delayed by exactly 3 cycles.
- Ignored load:
  - Stimulus: during SHIFT of 16'hFFFF, pulse load with D=16'h0000.
  - Required: 16 ones are still emitted; no restart; a single done pulse.
- Abort:
  - Stimulus: rst=0 after 5 bits of 16'h1234.
  - Required: outputs return to reset values at once and no done pulse. A following load of 16'h00FF then emits 8 zeros followed by 8 ones.
- LSB_FIRST=1 instance:
  - Stimulus: D=16'h0001.
  - Required: sout=1 in cycle 1, then 15 zeros; done in cycle 17.
